// File: rtl/spi_regfile_pkg.sv
// Shared constants and FSM state type for the SPI register-file back end.
package spi_regfile_pkg;

    localparam int ADRSIZE_DEF  = 8;
    localparam int DATASIZE_DEF = 32;
    localparam int WRITE_BIT    = ADRSIZE_DEF - 1;

    // Readback word for addresses that decode to no register.
    localparam logic [31:0] BAD_READ = 32'hDEAD_DEAD;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT_DATA,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/spi_regfile_sync2.sv
// Two-flop level synchronizer for the sclk-domain latch flags.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Shift the asynchronous level through two flops to settle metastability.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/spi_regfile.sv
// Register file behind the SPI slave: syncs latch flags, decodes the address,
// serves readback data and commits writes to the control registers.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int ADRSIZE  = ADRSIZE_DEF,
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int NRW      = 8,
    parameter int NRO      = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    adr_latched,
    input  logic                    data_latched,
    input  logic [ADRSIZE-1:0]      adr,
    input  logic [DATASIZE-1:0]     data_out,
    output logic [DATASIZE-1:0]     data_in,
    output logic [NRW*DATASIZE-1:0] ctrl,
    input  logic [NRO*DATASIZE-1:0] status,
    output logic [NRW-1:0]          wr_strobe,
    output logic [7:0]              err_count
);

    logic                w_aSync;
    logic                w_dSync;
    state_t              r_state;
    state_t              w_nextState;
    logic [ADRSIZE-1:0]  r_adrQ;
    logic [1:0]          r_armCnt;
    logic                r_errSeen;
    logic [DATASIZE-1:0] r_dataIn;
    logic [DATASIZE-1:0] r_ctrl [NRW];
    logic [NRW-1:0]      r_wrStrobe;
    logic [7:0]          r_errCount;

    logic [31:0]         w_idx;
    logic                w_isWrite;
    logic                w_isCtrl;
    logic                w_isStatus;
    logic [DATASIZE-1:0] w_readWord;
    logic                w_errEvent;
    logic                w_errInc;
    logic                w_doWrite;

    sync2 u_syncAdr (.clock(clock), .reset(reset), .d(adr_latched),  .q(w_aSync));
    sync2 u_syncDat (.clock(clock), .reset(reset), .d(data_latched), .q(w_dSync));

    assign w_idx      = 32'(r_adrQ[ADRSIZE-2:0]);
    assign w_isWrite  = r_adrQ[ADRSIZE-1];
    assign w_isCtrl   = (w_idx < 32'(NRW));
    assign w_isStatus = !w_isCtrl && (w_idx < 32'(NRW + NRO));
    assign w_doWrite  = (r_state == ST_COMMIT) && w_isWrite && w_isCtrl;

    // Select the readback word for the captured index, defaulting to the bad-read marker.
    always_comb begin
        w_readWord = DATASIZE'(BAD_READ);
        for (int i = 0; i < NRW; i++) begin
            if (w_idx == 32'(i)) w_readWord = r_ctrl[i];
        end
        for (int j = 0; j < NRO; j++) begin
            if (w_idx == 32'(NRW + j)) w_readWord = status[j*DATASIZE +: DATASIZE];
        end
    end

    // Flag the error conditions; only the first one seen in a frame is counted.
    always_comb begin
        w_errEvent = 1'b0;
        if (r_state == ST_LOOKUP && !w_isCtrl && !w_isStatus) w_errEvent = 1'b1;
        if (r_state == ST_WAIT_DATA && !w_dSync && !w_aSync)  w_errEvent = 1'b1;
        if (r_state == ST_COMMIT && w_isWrite && !w_isCtrl)   w_errEvent = 1'b1;
        w_errInc = w_errEvent && !r_errSeen;
    end

    // Next-state logic; ARM waits for the synchronizers to settle before trusting a_s low.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_ARM:       if (r_armCnt == 2'd2 && !w_aSync) w_nextState = ST_IDLE;
            ST_IDLE:      if (w_aSync) w_nextState = ST_LOOKUP;
            ST_LOOKUP:    w_nextState = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                if (w_dSync)       w_nextState = ST_COMMIT;
                else if (!w_aSync) w_nextState = ST_IDLE;
            end
            ST_COMMIT:    w_nextState = ST_ARM;
            default:      w_nextState = ST_ARM;
        endcase
    end

    // State register, address capture and the ARM settle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_ARM;
            r_adrQ   <= '0;
            r_armCnt <= 2'd0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_IDLE && w_aSync) r_adrQ <= adr;
            if (r_state != ST_ARM)             r_armCnt <= 2'd0;
            else if (r_armCnt != 2'd2)         r_armCnt <= r_armCnt + 2'd1;
        end
    end

    // Readback load, control register writes and the one-cycle write strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dataIn   <= '0;
            r_wrStrobe <= '0;
            for (int i = 0; i < NRW; i++) r_ctrl[i] <= '0;
        end else begin
            r_wrStrobe <= '0;
            if (r_state == ST_LOOKUP) r_dataIn <= w_readWord;
            for (int i = 0; i < NRW; i++) begin
                if (w_doWrite && w_idx == 32'(i)) begin
                    r_ctrl[i]     <= data_out;
                    r_wrStrobe[i] <= 1'b1;
                end
            end
        end
    end

    // Saturating error counter with a per-frame guard against double counting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_errCount <= 8'd0;
            r_errSeen  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_aSync) r_errSeen <= 1'b0;
            else if (w_errInc)                 r_errSeen <= 1'b1;
            if (w_errInc && r_errCount != 8'hFF) r_errCount <= r_errCount + 8'd1;
        end
    end

    genvar g;
    for (g = 0; g < NRW; g++) begin : g_ctrlOut
        assign ctrl[g*DATASIZE +: DATASIZE] = r_ctrl[g];
    end

    assign data_in   = r_dataIn;
    assign wr_strobe = r_wrStrobe;
    assign err_count = r_errCount;

endmodule

// File: tb/tb_spi_regfile.sv
// Randomized self-checking bench for spi_regfile against a frame-level model.
module tb_spi_regfile;

    logic         clock;
    logic         reset;
    logic         adr_latched;
    logic         data_latched;
    logic [7:0]   adr;
    logic [31:0]  data_out;
    logic [31:0]  data_in;
    logic [255:0] ctrl;
    logic [255:0] status;
    logic [7:0]   wr_strobe;
    logic [7:0]   err_count;

    logic [31:0]  ctrlModel   [8];
    logic [31:0]  statusModel [8];
    int           errModel;
    int           totalChecks;
    int           badChecks;

    spi_regfile dut (
        .clock(clock), .reset(reset),
        .adr_latched(adr_latched), .data_latched(data_latched),
        .adr(adr), .data_out(data_out), .data_in(data_in),
        .ctrl(ctrl), .status(status),
        .wr_strobe(wr_strobe), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive the status bus from the model's status words.
    always_comb begin
        status = '0;
        for (int j = 0; j < 8; j++) status[j*32 +: 32] = statusModel[j];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAllCtrl(input string tag);
        for (int i = 0; i < 8; i++) checkOutput(tag, ctrl[i*32 +: 32], ctrlModel[i]);
    endtask

    // One SPI frame as seen by the register file: address, optional data, then release.
    task automatic applyStimulus(input logic [7:0] a, input logic [31:0] wdata, input bit abortIt);
        int          k;
        bit          wr;
        bit          bad;
        logic [31:0] expRead;
        int          nHigh;
        int          firstHigh;
        logic [7:0]  seenBits;
        k  = int'(a[6:0]);
        wr = a[7];
        if (k < 8)       expRead = ctrlModel[k];
        else if (k < 16) expRead = statusModel[k-8];
        else             expRead = 32'hDEAD_DEAD;
        bad = (k >= 16) || abortIt || (wr && k >= 8);

        @(negedge clock);
        adr = a;
        adr_latched = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        checkOutput("readback", data_in, expRead);
        for (int j = 0; j < 8; j++) statusModel[j] = $urandom;

        if (abortIt) begin
            @(negedge clock);
            adr_latched = 1'b0;
            repeat (6) @(negedge clock);
        end else begin
            @(negedge clock);
            data_out = wdata;
            data_latched = 1'b1;
            nHigh = 0;
            firstHigh = -1;
            seenBits = 8'd0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clock);
                if (wr_strobe != 8'd0) begin
                    nHigh++;
                    seenBits = seenBits | wr_strobe;
                    if (firstHigh < 0) firstHigh = c;
                end
            end
            if (wr && k < 8) begin
                ctrlModel[k] = wdata;
                checkOutput("strobeCount", 32'(nHigh), 32'd1);
                checkOutput("strobeBits", 32'(seenBits), 32'(1 << k));
                checkOutput("strobeLatency", 32'(firstHigh > 0 && firstHigh <= 4), 32'd1);
            end else begin
                checkOutput("strobeCount", 32'(nHigh), 32'd0);
            end
            checkOutput("heldRead", data_in, expRead);
            checkAllCtrl("ctrl");
        end

        if (bad && errModel < 255) errModel++;
        checkOutput("errCount", 32'(err_count), 32'(errModel));

        @(negedge clock);
        adr_latched = 1'b0;
        data_latched = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    initial begin
        int          cat;
        int          k;
        bit          wr;
        int          nHigh;
        logic [7:0]  a;

        totalChecks = 0;
        badChecks   = 0;
        errModel    = 0;
        for (int i = 0; i < 8; i++) begin
            ctrlModel[i]   = 32'd0;
            statusModel[i] = $urandom;
        end
        reset = 1'b1;
        adr_latched = 1'b0;
        data_latched = 1'b0;
        adr = 8'd0;
        data_out = 32'd0;

        repeat (3) @(negedge clock);
        checkOutput("rstDataIn", data_in, 32'd0);
        checkOutput("rstStrobe", 32'(wr_strobe), 32'd0);
        checkOutput("rstErr", 32'(err_count), 32'd0);
        checkAllCtrl("rstCtrl");
        reset = 1'b0;
        repeat (6) @(negedge clock);

        applyStimulus(8'h83, 32'h1234_5678, 1'b0);
        statusModel[1] = 32'hCAFE_F00D;
        applyStimulus(8'h09, 32'h0, 1'b0);
        applyStimulus(8'h7F, 32'h0, 1'b0);
        applyStimulus(8'h8A, 32'h5555_AAAA, 1'b0);
        checkOutput("errAfterBad", 32'(err_count), 32'd2);
        applyStimulus(8'h02, 32'h0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            cat = $urandom_range(0, 2);
            if (cat == 0)      k = $urandom_range(0, 7);
            else if (cat == 1) k = $urandom_range(8, 15);
            else               k = $urandom_range(16, 127);
            wr = 1'($urandom_range(0, 1));
            a  = {wr, 7'(k)};
            applyStimulus(a, $urandom, ($urandom_range(0, 5) == 0));
        end

        @(negedge clock);
        adr = 8'h81;
        adr_latched = 1'b1;
        repeat (6) @(negedge clock);
        data_out = 32'hA5A5_0001;
        data_latched = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) ctrlModel[i] = 32'd0;
        errModel = 0;
        checkAllCtrl("midRstCtrl");
        checkOutput("midRstStrobe", 32'(wr_strobe), 32'd0);
        checkOutput("midRstErr", 32'(err_count), 32'd0);
        checkOutput("midRstDataIn", data_in, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        nHigh = 0;
        repeat (12) begin
            @(negedge clock);
            if (wr_strobe != 8'd0) nHigh++;
        end
        checkOutput("staleStrobe", 32'(nHigh), 32'd0);
        checkOutput("staleCtrl1", ctrl[32 +: 32], 32'd0);
        adr_latched = 1'b0;
        data_latched = 1'b0;
        repeat (6) @(negedge clock);
        applyStimulus(8'h81, 32'h0BAD_F00D, 1'b0);

        for (int n = 0; n < 300; n++) begin
            a = {1'b0, 7'($urandom_range(16, 127))};
            applyStimulus(a, 32'h0, 1'b0);
        end
        checkOutput("errSaturated", 32'(err_count), 32'd255);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
